// File: rtl/alu_op_scheduler_pkg.sv
// Opcode map, scheduler state encoding and opcode classification shared by
// the scheduler, its divider and the bench.
package alu_op_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_LE   = 4'd12;
  localparam logic [3:0] OP_RAND = 4'd13;
  localparam logic [3:0] OP_ROR  = 4'd14;
  localparam logic [3:0] OP_RXOR = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIVW = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Two request channels and one tagged response channel of the shared operator.
interface alu_op_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_op_scheduler_serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses exactly
// WIDTH cycles after start. Divide by zero naturally gives all ones / a.
module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH-1:0] rem_in, quo_in, div_in, rem_step, quo_step;
  logic [WIDTH:0]   shifted;

  // The first quotient bit is resolved in the start cycle, so WIDTH-1 busy
  // cycles finish the job and results are registered when done is shown.
  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    div_in = div_q;
    if (start) begin
      rem_in = '0;
      quo_in = a;
      div_in = b;
    end
    shifted  = {rem_in, quo_in[WIDTH-1]};
    quo_step = {quo_in[WIDTH-2:0], 1'b0};
    rem_step = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, div_in}) begin
      rem_step    = WIDTH'(shifted - {1'b0, div_in});
      quo_step[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= rem_step;
      quo_q  <= quo_step;
      div_q  <= b;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end else begin
        rem_q <= rem_step;
        quo_q <= quo_step;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one integer operator between two requesters;
// single-cycle ops answer next cycle, DIV/MOD go through the serial divider.
module alu_op_scheduler
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_scheduler_if.slave   bus
);
  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             is_mod_q, is_mod_d;

  logic             gnt0, gnt1, accept, div_start;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  // Shifting by an amount >= WIDTH already yields zero in SV semantics.
  function automatic logic [WIDTH-1:0] alu_eval(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_SHL:  return a << b;
      OP_SHR:  return a >> b;
      OP_EQ:   return WIDTH'(a == b);
      OP_LE:   return WIDTH'(a <= b);
      OP_RAND: return WIDTH'(&a);
      OP_ROR:  return WIDTH'(|a);
      OP_RXOR: return WIDTH'(^a);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (!ptr_q) begin
        gnt0 = bus.req0_valid;
        gnt1 = !bus.req0_valid && bus.req1_valid;
      end else begin
        gnt1 = bus.req1_valid;
        gnt0 = !bus.req1_valid && bus.req0_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign accept    = gnt0 || gnt1;
  assign sel_op    = gnt1 ? bus.req1_op : bus.req0_op;
  assign sel_a     = gnt1 ? bus.req1_a  : bus.req0_a;
  assign sel_b     = gnt1 ? bus.req1_b  : bus.req0_b;
  assign div_start = accept && is_multicycle(sel_op);

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (sel_a),
    .b         (sel_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    is_mod_d   = is_mod_q;
    case (state_q)
      IDLE: if (accept) begin
        ptr_d    = gnt0;
        rsp_id_d = gnt1;
        if (is_multicycle(sel_op)) begin
          is_mod_d = (sel_op == OP_MOD);
          state_d  = DIVW;
        end else begin
          rsp_data_d = alu_eval(sel_op, sel_a, sel_b);
          state_d    = RESP;
        end
      end
      DIVW: if (div_done) begin
        rsp_data_d = is_mod_q ? div_rem : div_quo;
        state_d    = RESP;
      end else if (!div_busy) begin
        state_d = IDLE;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      is_mod_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      is_mod_q   <= is_mod_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler at WIDTH=32 with hand-computed results.
module tb_alu_op_scheduler;
  import alu_op_pkg::*;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  alu_op_scheduler_if #(.WIDTH(W)) bus ();

  alu_op_scheduler #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input logic v, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Counts negedges until rsp_valid is seen; 0 means it never came.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 100);
    if (!bus.rsp_valid) lat = 0;
  endtask

  task automatic run_op(input string tag, input bit id, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_data);
    int   n;
    int   lat;
    logic seen;
    drive(id, 1'b1, op, a, b);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = id ? bus.req1_ready : bus.req0_ready;
    end
    check({tag, ".accept"}, W'(seen), W'(1));
    @(posedge clk); #1;
    drive(id, 1'b0, 4'd0, '0, '0);
    wait_rsp(lat);
    check({tag, ".latency"}, W'(lat), W'(exp_lat));
    check({tag, ".id"}, W'(bus.rsp_id), W'(id));
    check({tag, ".data"}, bus.rsp_data, exp_data);
    $display("%s: id=%0d data=0x%h latency=%0d", tag, bus.rsp_id, bus.rsp_data, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int lat;

    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    drive(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    check("reset.ready0", W'(bus.req0_ready), W'(0));
    check("reset.ready1", W'(bus.req1_ready), W'(0));
    check("reset.rsp_valid", W'(bus.rsp_valid), W'(0));
    check("reset.rsp_id", W'(bus.rsp_id), W'(0));
    check("reset.rsp_data", bus.rsp_data, 32'h0);
    drive(0, 1'b0, 4'd0, '0, '0);
    drive(1, 1'b0, 4'd0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add",  0, OP_ADD,  32'd5, 32'd10, 1, 32'd15);
    run_op("sub",  0, OP_SUB,  32'd5, 32'd10, 1, 32'hFFFF_FFFB);
    run_op("div",  1, OP_DIV,  32'd10, 32'd5, 33, 32'd2);
    run_op("mod",  1, OP_MOD,  32'd10, 32'd3, 33, 32'd1);
    run_op("and",  0, OP_AND,  32'h1, 32'h9, 1, 32'h1);
    run_op("xnor", 0, OP_XNOR, 32'h1, 32'h9, 1, 32'hFFFF_FFF7);
    run_op("rand", 0, OP_RAND, 32'hFFFF_FFFF, 32'h0, 1, 32'h1);
    run_op("rxor", 0, OP_RXOR, 32'h9, 32'h0, 1, 32'h0);
    run_op("shl",  0, OP_SHL,  32'h9, 32'd1, 1, 32'h12);
    run_op("shr",  0, OP_SHR,  32'h9, 32'd40, 1, 32'h0);
    run_op("mul",  1, OP_MUL,  32'h0001_0001, 32'h0001_0001, 1, 32'h0002_0001);
    run_op("eq",   1, OP_EQ,   32'd7, 32'd7, 1, 32'h1);
    run_op("le",   1, OP_LE,   32'd8, 32'd7, 1, 32'h0);
    run_op("div0", 1, OP_DIV,  32'd7, 32'd0, 33, 32'hFFFF_FFFF);
    run_op("mod0", 0, OP_MOD,  32'd7, 32'd0, 33, 32'd7);

    // Round-robin from a fresh reset with both requesters always valid.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    drive(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(lat);
      check($sformatf("rr%0d.seen", k), W'(lat != 0), W'(1));
      check($sformatf("rr%0d.id", k), W'(bus.rsp_id), W'(k % 2));
      check($sformatf("rr%0d.data", k), bus.rsp_data, (k % 2) ? 32'd4 : 32'd2);
      $display("rr%0d: id=%0d data=0x%h", k, bus.rsp_id, bus.rsp_data);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, '0, '0);
    drive(1, 1'b0, 4'd0, '0, '0);
    @(posedge clk); #1;

    // Back-pressure: result held while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    check("bp.accept", W'(bus.req0_ready), W'(1));
    @(posedge clk); #1;
    drive(0, 1'b1, OP_SUB, 32'd9, 32'd1);
    drive(1, 1'b1, OP_SUB, 32'd9, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d.valid", k), W'(bus.rsp_valid), W'(1));
      check($sformatf("bp%0d.data", k), bus.rsp_data, 32'd7);
      check($sformatf("bp%0d.id", k), W'(bus.rsp_id), W'(0));
      check($sformatf("bp%0d.ready0", k), W'(bus.req0_ready), W'(0));
      check($sformatf("bp%0d.ready1", k), W'(bus.req1_ready), W'(0));
      @(posedge clk); #1;
    end
    $display("bp: id=%0d data=0x%h held 3 cycles", bus.rsp_id, bus.rsp_data);
    drive(0, 1'b0, 4'd0, '0, '0);
    drive(1, 1'b0, 4'd0, '0, '0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp.release", W'(bus.rsp_valid), W'(0));
    @(posedge clk); #1;

    // Reset while the divider is running aborts the operation.
    drive(0, 1'b1, OP_DIV, 32'd100, 32'd3);
    @(negedge clk);
    check("rstdiv.accept", W'(bus.req0_ready), W'(1));
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, '0, '0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstdiv.valid_in_rst", W'(bus.rsp_valid), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    check("rstdiv.no_rsp", W'(cnt), W'(0));
    @(posedge clk); #1;
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    drive(1, 1'b1, OP_ADD, 32'd9, 32'd9);
    @(negedge clk);
    check("rstdiv.grant0", W'(bus.req0_ready), W'(1));
    check("rstdiv.grant1", W'(bus.req1_ready), W'(0));
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, '0, '0);
    drive(1, 1'b0, 4'd0, '0, '0);
    wait_rsp(lat);
    check("rstdiv.latency", W'(lat), W'(1));
    check("rstdiv.id", W'(bus.rsp_id), W'(0));
    check("rstdiv.data", bus.rsp_data, 32'd3);
    $display("rstdiv: id=%0d data=0x%h", bus.rsp_id, bus.rsp_data);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
